// File: rtl/uart_buf_ctrl.sv
// ---------------------------------------------------------------------------
// uart_buf_ctrl
// Circular-FIFO controller sitting between a UART receiver, a dual-port RAM
// and a UART transmitter. Received bytes are written through RAM port A;
// while the block is "running" they are read back through port B and handed
// to the transmitter one at a time. A debounced key press toggles
// run/pause.
//
// Parameters
//   ADDR_W  RAM address width, DEPTH = 2**ADDR_W
//   RD_LAT  RAM port-B read latency in clocks (1..15)
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   key_flag, key_state   debounced key strobe / level (press = flag & ~state)
//   rx_done, tx_done      UART byte-complete strobes
//   wea, addra            RAM write enable / write pointer
//   addrb                 RAM read pointer
//   send_en               one-cycle transmit start pulse
//   full, empty, running  status
//
// Optional feature (macro UART_BUF_CTRL_STAT_EN):
//   ovf    sticky flag, set when an rx_done is dropped because the buffer
//          is full; cleared by reset and by a pause->run key press
//   level  current fill count (ADDR_W+1 bits)
// ---------------------------------------------------------------------------
module uart_buf_ctrl #(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              key_flag,
  input  logic              key_state,
  input  logic              rx_done,
  input  logic              tx_done,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [ADDR_W-1:0] addrb,
  output logic              send_en,
  output logic              full,
  output logic              empty,
  output logic              running
`ifdef UART_BUF_CTRL_STAT_EN
  ,
  output logic              ovf,
  output logic [ADDR_W:0]   level
`endif
);

  // Level of a completely full buffer: only the MSB of the ADDR_W+1 count.
  localparam logic [ADDR_W:0] LVL_FULL = {1'b1, {ADDR_W{1'b0}}};
  // Last value of the latency counter before moving on to SEND.
  localparam logic [3:0]      LAT_LAST = 4'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAT     = 2'd1,
    SEND    = 2'd2,
    WAIT_TX = 2'd3
  } state_e;

  state_e              state_q,   state_d;
  logic [ADDR_W-1:0]   addra_q,   addra_d;
  logic [ADDR_W-1:0]   addrb_q,   addrb_d;
  logic [ADDR_W:0]     level_q,   level_d;
  logic                running_q, running_d;
  logic                send_en_q, send_en_d;
  logic [3:0]          lat_cnt_q, lat_cnt_d;

  logic press;
  logic wr_acc;
  logic rd_done;

  // ---------------------------------------------------------------------
  // Write side, level and run/pause
  // ---------------------------------------------------------------------
  always_comb begin
    press   = key_flag & ~key_state;
    // full is decoded from the level register, so a write is refused
    // whenever the buffer holds DEPTH bytes regardless of pointer values.
    wr_acc  = rx_done & ~full;
    // Only a tx_done that arrives while waiting on the transmitter
    // retires a byte; stray strobes elsewhere are ignored.
    rd_done = (state_q == WAIT_TX) & tx_done;

    addra_d   = wr_acc  ? addra_q + 1'b1 : addra_q;  // natural wrap mod DEPTH
    addrb_d   = rd_done ? addrb_q + 1'b1 : addrb_q;
    running_d = running_q ^ press;

    level_d = level_q;
    unique case ({wr_acc, rd_done})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;  // none, or write+read cancel out
    endcase
  end

  // ---------------------------------------------------------------------
  // Read FSM
  //   IDLE    : addrb already addresses the next byte, so the RAM read
  //             is in progress the moment we leave this state.
  //   LAT     : wait RD_LAT cycles for the RAM data.
  //   SEND    : request the transmit pulse (registered, visible next cycle).
  //   WAIT_TX : wait for the transmitter to finish the byte.
  // A pause only blocks the IDLE->LAT decision, so a byte already in
  // flight always completes.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    send_en_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        lat_cnt_d = '0;
        if (running_q && (level_q != '0)) state_d = LAT;
      end
      LAT: begin
        if (lat_cnt_q == LAT_LAST) begin
          state_d = SEND;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      SEND: begin
        send_en_d = 1'b1;
        state_d   = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      addra_q   <= '0;
      addrb_q   <= '0;
      level_q   <= '0;
      running_q <= 1'b0;
      send_en_q <= 1'b0;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addra_q   <= addra_d;
      addrb_q   <= addrb_d;
      level_q   <= level_d;
      running_q <= running_d;
      send_en_q <= send_en_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

`ifdef UART_BUF_CTRL_STAT_EN
  // ---------------------------------------------------------------------
  // Statistics: sticky overflow flag and exported fill level. A drop in
  // the same cycle as the clearing key press still leaves ovf set, so no
  // lost byte goes unreported.
  // ---------------------------------------------------------------------
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (press && !running_q) ovf_d = 1'b0;
    if (rx_done && full)     ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ovf_q <= 1'b0;
    else          ovf_q <= ovf_d;
  end

  assign ovf   = ovf_q;
  assign level = level_q;
`endif

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign wea     = wr_acc;
  assign addra   = addra_q;
  assign addrb   = addrb_q;
  assign send_en = send_en_q;
  assign full    = (level_q == LVL_FULL);
  assign empty   = (level_q == '0);
  assign running = running_q;

endmodule

// File: tb/tb_uart_buf_ctrl.sv
// ---------------------------------------------------------------------------
// Self-checking bench for uart_buf_ctrl (ADDR_W=3 so wrap and full are cheap
// to reach, RD_LAT=3). A transaction-level model (byte count, write/read
// byte totals, "cycles since a byte was started") predicts every output on
// every clock; table vectors and directed sequences add explicit checks.
// ---------------------------------------------------------------------------
module tb_uart_buf_ctrl;
  localparam int AW    = 3;
  localparam int LAT   = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          key_flag = 1'b0, key_state = 1'b1, rx_done = 1'b0, tx_done = 1'b0;
  logic          wea, send_en, full, empty, running;
  logic [AW-1:0] addra, addrb;
`ifdef UART_BUF_CTRL_STAT_EN
  logic          ovf;
  logic [AW:0]   level;
`endif

  always #10 clk = ~clk;

  uart_buf_ctrl #(.ADDR_W(AW), .RD_LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .key_flag(key_flag), .key_state(key_state),
    .rx_done(rx_done), .tx_done(tx_done), .wea(wea), .addra(addra),
    .addrb(addrb), .send_en(send_en), .full(full), .empty(empty),
    .running(running)
`ifdef UART_BUF_CTRL_STAT_EN
    , .ovf(ovf), .level(level)
`endif
  );

  int n_tests = 0, n_fail = 0;
  int dut_sends = 0;
  bit seen_send = 0;

  // ---------------- reference model ----------------
  int m_cnt, m_wr_tot, m_rd_tot, m_since;
  bit m_run, m_busy, m_ovf;

  task automatic m_reset();
    m_cnt = 0; m_wr_tot = 0; m_rd_tot = 0; m_since = 0;
    m_run = 0; m_busy = 0; m_ovf = 0;
  endtask

  // One clock edge: a byte is started when idle, running and not empty; its
  // transmit pulse appears LAT+1 edges later; from then on tx_done retires it.
  task automatic m_step();
    bit press, acc, drop, done, start;
    press = key_flag && !key_state;
    acc   = rx_done && (m_cnt < DEPTH);
    drop  = rx_done && (m_cnt == DEPTH);
    done  = m_busy && (m_since >= LAT + 1) && tx_done;
    start = !m_busy && m_run && (m_cnt != 0);
    if (acc)  begin m_cnt++; m_wr_tot++; end
    if (done) begin m_cnt--; m_rd_tot++; end
    if (press && !m_run) m_ovf = 0;
    if (drop) m_ovf = 1;
    if (press) m_run = !m_run;
    if (done)       m_busy = 0;
    else if (start) begin m_busy = 1; m_since = 0; end
    else if (m_busy) m_since++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("wea",     32'(wea),     32'(rx_done && (m_cnt < DEPTH)));
    chk("addra",   32'(addra),   32'(m_wr_tot % DEPTH));
    chk("addrb",   32'(addrb),   32'(m_rd_tot % DEPTH));
    chk("full",    32'(full),    32'(m_cnt == DEPTH));
    chk("empty",   32'(empty),   32'(m_cnt == 0));
    chk("running", 32'(running), 32'(m_run));
    chk("send_en", 32'(send_en), 32'(m_busy && (m_since == LAT + 1)));
`ifdef UART_BUF_CTRL_STAT_EN
    chk("ovf",     32'(ovf),     32'(m_ovf));
    chk("level",   32'(level),   32'(m_cnt));
`endif
  endtask

  // Drive inputs, check outputs at the negedge, step model at the posedge.
  task automatic cycle(input bit kf, input bit ks, input bit rx, input bit tx);
    key_flag = kf; key_state = ks; rx_done = rx; tx_done = tx;
    @(negedge clk);
    check_model();
    seen_send = send_en;
    if (send_en) dut_sends++;
    @(posedge clk);
    m_step();
    #1;
  endtask

  // Idle cycles answering every send_en with tx_done txd+1 cycles later.
  // Returns the index of the cycle in which the first send_en was seen.
  task automatic run(input int n, input int txd, input bit rnd_rx, output int first);
    int t;
    t = -1; first = -1;
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 1'b1, rnd_rx ? ($urandom_range(0, 3) == 0) : 1'b0, t == 0);
      if (t >= 0) t--;
      if (seen_send) begin
        t = txd;
        if (first < 0) first = i;
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    key_flag = 0; key_state = 1; tx_done = 0; rx_done = 1;
    m_reset();
    #1;
    chk("rst_addra", 32'(addra), 0);
    chk("rst_addrb", 32'(addrb), 0);
    chk("rst_send",  32'(send_en), 0);
    chk("rst_full",  32'(full), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_run",   32'(running), 0);
    chk("rst_wea",   32'(wea), 1);   // wea follows rx_done in reset
    rx_done = 0;
    #1;
    chk("rst_wea0",  32'(wea), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  typedef struct {
    bit rx;
    bit exp_wea;
    int exp_addra;
    bit exp_empty;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int first, s0;
    bit found;

    vecs[0] = '{1, 1, 0, 1}; vecs[1] = '{1, 1, 1, 0};
    vecs[2] = '{0, 0, 2, 0}; vecs[3] = '{1, 1, 2, 0};
    vecs[4] = '{1, 1, 3, 0}; vecs[5] = '{0, 0, 4, 0};
    vecs[6] = '{1, 1, 4, 0}; vecs[7] = '{0, 0, 5, 0};

    // ---- power-on reset, 5 bytes received while paused ----
    @(posedge clk);
    #2 do_reset();
    for (int i = 0; i < 8; i++) begin
      rx_done = vecs[i].rx;
      #1;
      chk("vec_wea",   32'(wea),   32'(vecs[i].exp_wea));
      chk("vec_addra", 32'(addra), 32'(vecs[i].exp_addra));
      chk("vec_empty", 32'(empty), 32'(vecs[i].exp_empty));
      cycle(1'b0, 1'b1, vecs[i].rx, 1'b0);
    end
    chk("fill_addra", 32'(addra), 5);
    chk("fill_sends", 32'(dut_sends), 0);

    // ---- press: drain 5 bytes, tx_done 20 cycles after each send_en ----
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    run(200, 19, 1'b0, first);
    chk("first_send_cycle", 32'(first), 5);  // 1 edge to leave IDLE + RD_LAT+1
    chk("drain_sends", 32'(dut_sends), 5);
    chk("drain_addrb", 32'(addrb), 5);
    chk("drain_empty", 32'(empty), 1);
    chk("drain_run",   32'(running), 1);

    // ---- overflow: 10 bytes while paused into 8 entries ----
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    chk("ovf_full",  32'(full), 1);
    chk("ovf_addra", 32'(addra), 0);
`ifdef UART_BUF_CTRL_STAT_EN
    chk("ovf_flag",  32'(ovf), 1);
`endif
    // resume with random traffic: multiple wraps, drops, ovf clear on press
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    run(400, 3, 1'b1, first);

    // ---- pause during LAT of byte 2 ----
    do_reset();
    s0 = dut_sends;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_rd_tot == 1 && m_busy && m_since == 1) found = 1;
      else cycle(1'b0, 1'b1, 1'b0, m_busy && (m_since >= LAT + 2));
    end
    chk("pause_reach", 32'(found), 1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    run(100, 3, 1'b0, first);
    chk("pause_sends", 32'(dut_sends - s0), 2);
    chk("pause_addrb", 32'(addrb), 2);
    chk("pause_run",   32'(running), 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    run(100, 3, 1'b0, first);
    chk("resume_sends", 32'(dut_sends - s0), 3);
    chk("resume_addrb", 32'(addrb), 3);

    // ---- simultaneous write and retire at level 3 ----
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (m_busy && m_since == LAT + 1) found = 1;
      else cycle(1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("both_reach", 32'(found), 1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    chk("both_addra", 32'(addra), 4);
    chk("both_addrb", 32'(addrb), 1);
    chk("both_full",  32'(full), 0);
    chk("both_empty", 32'(empty), 0);
`ifdef UART_BUF_CTRL_STAT_EN
    chk("both_level", 32'(level), 3);
`endif

    // ---- reset while waiting on the transmitter ----
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (m_busy && m_since == LAT + 3) found = 1;
      else cycle(1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("rstx_reach", 32'(found), 1);
    #2 do_reset();
    s0 = dut_sends;
    run(50, 3, 1'b0, first);
    chk("rstx_sends", 32'(dut_sends - s0), 0);

    // ---- random traffic against the model ----
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule
